// File: rtl/logic_unit_pipe_if.sv
// logic_unit_pipe_if: input/output handshake bundle for logic_unit_pipe.
//   InValid/InReady : input beat handshake
//   A, B, Op        : operands and operation select (0 AND .. 7 ORN)
//   Accum, Last     : burst start (multi-beat fold) and burst end markers
//   OutValid/OutReady : result handshake
//   Out, Zero       : result and its zero flag
//   Overflow        : burst force-terminated at MAX_BEATS
// master = producer/consumer side (testbench), slave = the unit.
interface logic_unit_pipe_if #(
  parameter int unsigned WIDTH = 32
);
  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       Op;
  logic             Accum;
  logic             Last;
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] Out;
  logic             Zero;
  logic             Overflow;

  modport master (
    output InValid, A, B, Op, Accum, Last, OutReady,
    input  InReady, OutValid, Out, Zero, Overflow
  );

  modport slave (
    input  InValid, A, B, Op, Accum, Last, OutReady,
    output InReady, OutValid, Out, Zero, Overflow
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: registered WIDTH-bit bitwise logic unit with eight
// operations and a multi-beat fold (accumulate) mode.
//   Clk : rising-edge clock
//   Rst : synchronous active-low reset
//   bus : logic_unit_pipe_if.slave (input beat handshake, operands,
//         result handshake, Out/Zero/Overflow)
// Single beats produce Out = f(A,B,Op) one cycle after acceptance.
// A burst folds acc = f(acc,A,opL) over successive beats until Last or
// MAX_BEATS beats, the latter flagged with Overflow.
module logic_unit_pipe #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MAX_BEATS = 16
) (
  input logic               Clk,
  input logic               Rst,
  logic_unit_pipe_if.slave  bus
);

  localparam int unsigned CW = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    HOLD
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic [2:0]       op_l;
  logic [WIDTH-1:0] out_r;
  logic             zero_r;
  logic             ovf_r;
  logic             out_valid_r;

  logic             in_ready;
  logic             fire;
  logic [WIDTH-1:0] first_res;
  logic [WIDTH-1:0] acc_res;
  logic [CW-1:0]    cnt_nxt;

  function automatic logic [WIDTH-1:0] lop(input logic [WIDTH-1:0] x,
                                           input logic [WIDTH-1:0] y,
                                           input logic [2:0]       op);
    logic [WIDTH-1:0] r;
    case (op)
      3'd0:    r = x & y;
      3'd1:    r = x | y;
      3'd2:    r = x ^ y;
      3'd3:    r = ~(x | y);
      3'd4:    r = ~(x & y);
      3'd5:    r = ~(x ^ y);
      3'd6:    r = x & ~y;
      default: r = x | ~y;
    endcase
    return r;
  endfunction

  // Ready depends only on state, OutReady and reset, never on InValid.
  always_comb begin
    in_ready = 1'b0;
    if (Rst) begin
      in_ready = (state == HOLD) ? bus.OutReady : 1'b1;
    end
  end

  always_comb begin
    fire      = bus.InValid && in_ready;
    first_res = lop(bus.A, bus.B, bus.Op);
    acc_res   = lop(acc, bus.A, op_l);
    cnt_nxt   = cnt + 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      op_l        <= '0;
      out_r       <= '0;
      zero_r      <= 1'b0;
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        // HOLD with OutReady=1 retires the held result and handles a new
        // beat exactly like IDLE in the same cycle.
        IDLE, HOLD: begin
          if (fire) begin
            if (!bus.Accum || bus.Last) begin
              out_r       <= first_res;
              zero_r      <= (first_res == '0);
              ovf_r       <= 1'b0;
              out_valid_r <= 1'b1;
              state       <= HOLD;
            end else begin
              acc         <= first_res;
              op_l        <= bus.Op;
              cnt         <= CW'(1);
              out_valid_r <= 1'b0;
              state       <= ACC;
            end
          end else if (state == HOLD && bus.OutReady) begin
            out_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end

        ACC: begin
          if (fire) begin
            cnt <= cnt_nxt;
            if (bus.Last || cnt_nxt == CW'(MAX_BEATS)) begin
              out_r       <= acc_res;
              zero_r      <= (acc_res == '0);
              ovf_r       <= !bus.Last;
              out_valid_r <= 1'b1;
              state       <= HOLD;
            end else begin
              acc <= acc_res;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.InReady  = in_ready;
  assign bus.OutValid = out_valid_r;
  assign bus.Out      = out_r;
  assign bus.Zero     = zero_r;
  assign bus.Overflow = ovf_r;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: directed and randomized checks of logic_unit_pipe
// against a burst-list reference model (operands collected per burst and
// folded when the burst ends).
module tb_logic_unit_pipe;

  localparam int unsigned W    = 32;
  localparam int unsigned MAXB = 16;

  logic Clk;
  logic rst;

  logic_unit_pipe_if #(.WIDTH(W)) bus ();

  logic_unit_pipe #(.WIDTH(W), .MAX_BEATS(MAXB)) dut (
    .Clk (Clk),
    .Rst (rst),
    .bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // reference model state
  logic [W-1:0] q[$];
  logic [2:0]   bop;
  logic         m_valid;
  logic [W-1:0] m_out;
  logic         m_zero;
  logic         m_ovf;

  function automatic logic [W-1:0] lop(input logic [W-1:0] x,
                                       input logic [W-1:0] y,
                                       input logic [2:0]   op);
    case (op)
      3'd0:    return x & y;
      3'd1:    return x | y;
      3'd2:    return x ^ y;
      3'd3:    return ~(x | y);
      3'd4:    return ~(x & y);
      3'd5:    return ~(x ^ y);
      3'd6:    return x & ~y;
      default: return x | ~y;
    endcase
  endfunction

  function automatic logic [W-1:0] fold_q();
    logic [W-1:0] r;
    r = q[0];
    for (int unsigned i = 1; i < q.size(); i++) r = lop(r, q[i], bop);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [W-1:0] r, input logic ovf);
    m_valid = 1'b1;
    m_out   = r;
    m_zero  = (r == '0);
    m_ovf   = ovf;
  endtask

  // One clock cycle with current inputs: check ready, update model, check outputs.
  task automatic tick();
    logic exp_rdy;
    logic fire;
    #1;
    exp_rdy = rst && (!m_valid || bus.OutReady);
    chk("in_ready", {63'd0, bus.InReady}, {63'd0, exp_rdy});
    fire = bus.InValid && exp_rdy;
    @(posedge Clk);
    #1;
    if (!rst) begin
      q.delete();
      m_valid = 1'b0;
      m_out   = '0;
      m_zero  = 1'b0;
      m_ovf   = 1'b0;
    end else begin
      if (m_valid && bus.OutReady) m_valid = 1'b0;
      if (fire) begin
        if (q.size() == 0) begin
          if (!bus.Accum || bus.Last) load(lop(bus.A, bus.B, bus.Op), 1'b0);
          else begin
            q.push_back(lop(bus.A, bus.B, bus.Op));
            bop = bus.Op;
          end
        end else begin
          q.push_back(bus.A);
          if (bus.Last) begin
            load(fold_q(), 1'b0);
            q.delete();
          end else if (q.size() == MAXB) begin
            load(fold_q(), 1'b1);
            q.delete();
          end
        end
      end
    end
    chk("out_valid", {63'd0, bus.OutValid}, {63'd0, m_valid});
    chk("out",       {32'd0, bus.Out},      {32'd0, m_out});
    chk("zero",      {63'd0, bus.Zero},     {63'd0, m_zero});
    chk("overflow",  {63'd0, bus.Overflow}, {63'd0, m_ovf});
  endtask

  task automatic beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                      input logic accum, input logic last);
    bus.InValid = 1'b1;
    bus.A       = a;
    bus.B       = b;
    bus.Op      = op;
    bus.Accum   = accum;
    bus.Last    = last;
  endtask

  logic [W-1:0] tbl[8];

  initial begin
    tbl[0] = 32'h00F0_000F; tbl[1] = 32'hFFF0_0FFF;
    tbl[2] = 32'hFF00_0FF0; tbl[3] = 32'h000F_F000;
    tbl[4] = 32'hFF0F_FFF0; tbl[5] = 32'h00FF_F00F;
    tbl[6] = 32'hF000_00F0; tbl[7] = 32'hF0FF_F0FF;

    m_valid = 1'b0; m_out = '0; m_zero = 1'b0; m_ovf = 1'b0; bop = '0;
    rst = 1'b0;
    beat(32'h1234_5678, 32'hFFFF_FFFF, 3'd0, 1'b0, 1'b0);
    bus.OutReady = 1'b1;

    // reset held two cycles with a beat offered
    repeat (2) tick();
    chk("rst_out", {32'd0, bus.Out}, 64'd0);
    chk("rst_valid", {63'd0, bus.OutValid}, 64'd0);
    rst = 1'b1;

    // single ops back-to-back, first one accepted right after release
    for (int unsigned i = 0; i < 8; i++) begin
      beat(32'hF0F0_00FF, 32'h0FF0_0F0F, 3'(i), 1'b0, 1'b0);
      tick();
      chk("single_op", {32'd0, bus.Out}, {32'd0, tbl[i]});
      chk("single_valid", {63'd0, bus.OutValid}, 64'd1);
    end

    // backpressure: result must hold, no beat accepted
    bus.OutReady = 1'b0;
    beat(32'hFFFF_FFFF, 32'h0000_ABCD, 3'd0, 1'b0, 1'b0);
    for (int unsigned i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold", {32'd0, bus.Out}, {32'd0, tbl[7]});
      chk("bp_ready", {63'd0, bus.InReady}, 64'd0);
    end
    bus.OutReady = 1'b1;
    tick();
    chk("bp_release", {32'd0, bus.Out}, 64'h0000_ABCD);

    // AND with zero
    beat(32'hDEAD_BEEF, 32'h0, 3'd0, 1'b0, 1'b0);
    tick();
    chk("zero_flag", {63'd0, bus.Zero}, 64'd1);
    bus.InValid = 1'b0;
    tick();

    // XOR accumulate with a 2-cycle gap
    beat(32'd1, 32'd2, 3'd2, 1'b1, 1'b0);
    tick();
    beat(32'd4, 32'hFFFF_FFFF, 3'd0, 1'b0, 1'b0);
    tick();
    bus.InValid = 1'b0;
    repeat (2) tick();
    chk("acc_gap_valid", {63'd0, bus.OutValid}, 64'd0);
    beat(32'd8, 32'hFFFF_FFFF, 3'd0, 1'b0, 1'b1);
    tick();
    chk("acc_out", {32'd0, bus.Out}, 64'h0000_000F);
    chk("acc_ovf", {63'd0, bus.Overflow}, 64'd0);

    // overflow: OR of 16 single bits, 17th beat opens a new burst
    for (int unsigned i = 0; i < 16; i++) begin
      beat(32'd1 << i, 32'd0, 3'd1, 1'b1, 1'b0);
      tick();
    end
    chk("ovf_out", {32'd0, bus.Out}, 64'h0000_FFFF);
    chk("ovf_flag", {63'd0, bus.Overflow}, 64'd1);
    beat(32'd1 << 16, 32'd0, 3'd1, 1'b1, 1'b0);
    tick();
    chk("ovf_next_valid", {63'd0, bus.OutValid}, 64'd0);
    beat(32'd0, 32'd0, 3'd0, 1'b0, 1'b1);
    tick();
    chk("ovf_next_out", {32'd0, bus.Out}, 64'h0001_0000);
    chk("ovf_next_flag", {63'd0, bus.Overflow}, 64'd0);

    // reset mid-burst
    for (int unsigned i = 0; i < 3; i++) begin
      beat(32'h0F0F_0F0F << i, 32'h3, 3'd2, 1'b1, 1'b0);
      tick();
    end
    rst = 1'b0;
    bus.InValid = 1'b0;
    tick();
    chk("mid_rst_valid", {63'd0, bus.OutValid}, 64'd0);
    rst = 1'b1;
    beat(32'hFFFF_FFFF, 32'h1234_5678, 3'd0, 1'b0, 1'b0);
    tick();
    chk("mid_rst_and", {32'd0, bus.Out}, 64'h1234_5678);

    // randomized traffic
    for (int unsigned i = 0; i < 600; i++) begin
      rst          = ($urandom_range(0, 99) != 0);
      bus.InValid  = ($urandom_range(0, 9) < 7);
      bus.OutReady = ($urandom_range(0, 9) < 7);
      bus.A        = $urandom;
      bus.B        = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      bus.Op       = 3'($urandom_range(0, 7));
      bus.Accum    = ($urandom_range(0, 1) == 1);
      bus.Last     = ($urandom_range(0, 9) < 2);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
# logic_unit_pipe

Parametrised, registered bitwise logic unit for the MIPS datapath, generalising the single-bit two-input AND gate to WIDTH-bit operands, eight selectable operations and a multi-beat accumulate (fold) mode. Input and output use valid/ready handshakes, with one registered output stage. It sits beside the ALU and serves AND/OR/XOR/NOR-class instructions plus multi-word mask folding.

## Interface
- WIDTH, 32, operand and result width in bits (≥1).
- MAX_BEATS, 16, maximum beats folded per accumulate burst (≥2).
- Clk  input  1  rising-edge clock; the only clock.
- Rst  input  1  synchronous, active-low reset.
- InValid  input  1  input beat present.
- InReady  output  1  unit accepts a beat this cycle. A beat is accepted when InValid and InReady are both high.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B; ignored on non-first beats of a burst.
- Op  input  3  operation: 0 AND, 1 OR, 2 XOR, 3 NOR, 4 NAND, 5 XNOR, 6 ANDN (A&~B), 7 ORN (A|~B).
- Accum  input  1  on the first beat of a burst, 1 starts a multi-beat fold.
- Last  input  1  final beat of a burst.
- OutValid  output  1  result valid.
- OutReady  input  1  consumer takes the result. A transfer happens when OutValid and OutReady are both high.
- Out  output  WIDTH  result.
- Zero  output  1  Out == 0; registered together with Out.
- Overflow  output  1  burst was force-terminated at MAX_BEATS.

## Operation
- f(x,y,op) is the bitwise function selected by op. All arithmetic is WIDTH bits; there is no carry.
- State IDLE (InReady=1). On an accepted beat:
  - If Accum=0 or Last=1: Out←f(A,B,Op), Overflow←0, go to HOLD.
  - Otherwise: acc←f(A,B,Op), opL←Op, cnt←1, go to ACC.
- State ACC (InReady=1). Op, Accum and B are ignored. On an accepted beat, t=f(acc,A,opL), cnt←cnt+1.
  - If Last=1: Out←t, Overflow←0, go to HOLD.
  - Else if cnt+1==MAX_BEATS: Out←t, Overflow←1, go to HOLD. The next beat starts a new burst.
  - Else: acc←t.
- State HOLD (OutValid=1). InReady=OutReady.
  - OutReady=1 with an accepted beat: the beat is processed exactly as in IDLE in the same cycle. Out is overwritten, or the unit goes to ACC with OutValid dropped.
  - OutReady=1 with no beat: OutValid←0, go to IDLE.
  - OutReady=0: Out, Zero and Overflow hold stable; no input is accepted.
- Cycles with InValid=0 in ACC leave the state unchanged. Bursts may have gaps.
- Reset (Rst=0 at a clock edge) overrides everything, including mid-burst or while holding a result:
  - state←IDLE; acc, cnt and opL←0.
  - OutValid=0, Out=0, Zero=0, Overflow=0.
  - InReady is 0 during the reset cycle.

## Timing
- Latency: the result appears 1 cycle after the edge that accepts a single beat or the last beat.
- Throughput for single-beat ops: 1 per cycle with OutReady held at 1.
- An N-beat burst produces 1 result after N accepted beats.
- InReady is combinational from state and OutReady only; it never depends on InValid.
- Outputs are registered. Out, Zero and Overflow change only on an edge where a new result is loaded or on reset.

## Test plan
- Reset: hold Rst=0 for 2 cycles with InValid=1, then release -> OutValid=0, Out=0, Zero=0, Overflow=0 during reset; first beat accepted on the cycle after release.
- Single ops: A=F0F0_00FF, B=0FF0_0F0F, Op 0..7 back-to-back with OutReady=1 -> outputs 00F0_000F, FFF0_0FFF, FF00_0FF0, 000F_F000, FF0F_FFF0, 00FF_F00F, F000_00F0, F0FF_F0FF, one per cycle with 1-cycle latency. Op 0 with B=0 -> Zero=1.
- Backpressure: OutReady=0 for 5 cycles after a result -> InReady=0, Out stable. Then OutReady=1 with a new beat -> old result transfers and new result appears next cycle.
- Accumulate: Op=XOR, Accum=1. Beats (A=1,B=2), A=4, A=8 (Last=1), with a 2-cycle InValid gap mid-burst -> single result 0000_000F, Overflow=0.
- Overflow: MAX_BEATS=16, Op=OR, 17 beats with A=1<<i and Last=0 -> result 0000_FFFF with Overflow=1 after beat 16. Beat 17 starts a new burst.
- Reset mid-burst: reset after 3 accumulate beats -> IDLE, OutValid=0. The next single AND beat yields only its own result.
